// File: rtl/led_mon_pkg.sv
// -----------------------------------------------------------------------------
// led_mon_pkg
// Shared types and helpers for the LED sequence monitor.
//   phase_t      : decoded LED code (GAP/RED/GREEN/BLUE/ILLEGAL); the low two
//                  bits double as the reported phase_id.
//   state_t      : monitor FSM states.
//   ERR_*        : err_code values.
//   phase_lim_t  : accepted minimum length and timeout limit of one phase.
//   decode_lines : {red, green, blue} -> phase_t.
//   next_phase   : legal successor of a phase.
//   phase_limits : expected-length window for a phase.
// -----------------------------------------------------------------------------
package led_mon_pkg;

    typedef enum logic [2:0] {
        PH_GAP     = 3'd0,
        PH_RED     = 3'd1,
        PH_GREEN   = 3'd2,
        PH_BLUE    = 3'd3,
        PH_ILLEGAL = 3'd4
    } phase_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RED   = 3'd1,
        ST_GREEN = 3'd2,
        ST_BLUE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL = 3'd1;
    localparam logic [2:0] ERR_ORDER   = 3'd2;
    localparam logic [2:0] ERR_SHORT   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    // Limits are kept at 64 bits so they never overflow for any counter width.
    typedef struct packed {
        logic [63:0] min_len;  // shortest accepted length on a code change
        logic [63:0] limit;    // count value that signals a timeout
    } phase_lim_t;

    function automatic phase_t decode_lines(input logic [2:0] lines);
        phase_t ph;
        case (lines)
            3'b000:  ph = PH_GAP;
            3'b100:  ph = PH_RED;
            3'b010:  ph = PH_GREEN;
            3'b001:  ph = PH_BLUE;
            default: ph = PH_ILLEGAL;
        endcase
        return ph;
    endfunction

    function automatic phase_t next_phase(input phase_t ph);
        phase_t nx;
        case (ph)
            PH_RED:   nx = PH_GREEN;
            PH_GREEN: nx = PH_BLUE;
            PH_BLUE:  nx = PH_GAP;
            PH_GAP:   nx = PH_RED;
            default:  nx = PH_ILLEGAL;
        endcase
        return nx;
    endfunction

    function automatic phase_t state_phase(input state_t st);
        phase_t ph;
        case (st)
            ST_RED:   ph = PH_RED;
            ST_GREEN: ph = PH_GREEN;
            ST_BLUE:  ph = PH_BLUE;
            ST_GAP:   ph = PH_GAP;
            default:  ph = PH_ILLEGAL;
        endcase
        return ph;
    endfunction

    function automatic state_t phase_state(input phase_t ph);
        state_t st;
        case (ph)
            PH_RED:   st = ST_RED;
            PH_GREEN: st = ST_GREEN;
            PH_BLUE:  st = ST_BLUE;
            PH_GAP:   st = ST_GAP;
            default:  st = ST_IDLE;
        endcase
        return st;
    endfunction

    // Coloured phases accept expected-tol .. expected+tol; the gap accepts
    // 1 .. gap_max. The timeout fires one count past the upper bound.
    function automatic phase_lim_t phase_limits(input phase_t ph,
                                                input logic [63:0] red,
                                                input logic [63:0] green,
                                                input logic [63:0] blue,
                                                input logic [63:0] tol,
                                                input logic [63:0] gap_max);
        phase_lim_t  lim;
        logic [63:0] exp_len;
        lim     = '0;
        exp_len = '0;
        case (ph)
            PH_RED:   exp_len = red;
            PH_GREEN: exp_len = green;
            PH_BLUE:  exp_len = blue;
            default:  exp_len = '0;
        endcase
        if (ph == PH_GAP) begin
            lim.min_len = 64'd1;
            lim.limit   = gap_max + 64'd1;
        end else begin
            lim.min_len = (exp_len > tol) ? (exp_len - tol) : 64'd0;
            lim.limit   = exp_len + tol + 64'd1;
        end
        return lim;
    endfunction

endpackage

// File: rtl/led_mon_if.sv
// -----------------------------------------------------------------------------
// led_mon_if
// Bundle between the LED lines, the monitor and the board status logic.
//   led_red/green/blue : raw LED lines (asynchronous to clk)
//   phase_valid        : one-cycle pulse, phase_id/phase_len valid with it
//   seq_err/err_code   : one-cycle error pulse, code holds until next error
//   locked/cycle_count : tracking status and completed-cycle counter
//   dbg_state          : monitor FSM state for observation
// Handshake: phase_valid and seq_err are single-cycle strobes with no ready
// and no back-pressure; a consumer must sample them in the cycle they are high.
// master = monitor side, slave = LED driver / status consumer side.
// -----------------------------------------------------------------------------
interface led_mon_if #(
    parameter int CNT_W = 32
);
    logic             led_red;
    logic             led_green;
    logic             led_blue;
    logic             phase_valid;
    logic [1:0]       phase_id;
    logic [CNT_W-1:0] phase_len;
    logic             seq_err;
    logic [2:0]       err_code;
    logic             locked;
    logic [15:0]      cycle_count;
    logic [2:0]       dbg_state;

    modport master (
        input  led_red, led_green, led_blue,
        output phase_valid, phase_id, phase_len, seq_err, err_code,
               locked, cycle_count, dbg_state
    );

    modport slave (
        output led_red, led_green, led_blue,
        input  phase_valid, phase_id, phase_len, seq_err, err_code,
               locked, cycle_count, dbg_state
    );
endinterface

// File: rtl/led_sync.sv
// -----------------------------------------------------------------------------
// led_sync
// Plain 2-flop synchroniser, one independent chain per bit.
//   clk, rst_n : clock, asynchronous active-low reset (flops clear to 0)
//   d          : asynchronous inputs
//   q          : synchronised outputs, two clocks after capture
// -----------------------------------------------------------------------------
module led_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/led_sequence_monitor.sv
// -----------------------------------------------------------------------------
// led_sequence_monitor
// Receives the red -> green -> blue -> gap LED sequence, measures each phase
// in clock cycles and checks order and duration.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : led_mon_if.master (LED lines in; phase/error/lock status out)
// Pipeline: 2-flop sync -> registered decode (code_q) -> code_prev; a code
// change is code_q != code_prev, so a line edge captured at clock n yields the
// registered pulse at clock n+3.
// -----------------------------------------------------------------------------
module led_sequence_monitor
    import led_mon_pkg::*;
#(
    parameter int unsigned RED_CYCLES     = 200_000_000,
    parameter int unsigned GREEN_CYCLES   = 110_000_000,
    parameter int unsigned BLUE_CYCLES    = 60_000_000,
    parameter int unsigned TOL_CYCLES     = 1000,
    parameter int unsigned GAP_MAX_CYCLES = 16,
    parameter int          CNT_W          = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    led_mon_if.master bus
);
    logic [2:0] lines_sync;
    phase_t     code_q, code_prev;
    logic       code_changed;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
    logic             valid_q, valid_n;
    logic [1:0]       id_q, id_n;
    logic [CNT_W-1:0] len_q, len_n;
    logic             err_q, err_n;
    logic [2:0]       code_out_q, code_out_n;
    logic             locked_q, locked_n;
    logic [15:0]      cc_q, cc_n;

    phase_t     cur_ph;
    phase_lim_t lim;
    logic [2:0] fault;

    led_sync #(.WIDTH(3)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({bus.led_red, bus.led_green, bus.led_blue}),
        .q     (lines_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= PH_GAP;
            code_prev <= PH_GAP;
        end else begin
            code_q    <= decode_lines(lines_sync);
            code_prev <= code_q;
        end
    end

    assign code_changed = (code_q != code_prev);
    assign cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            code_out_q <= ERR_NONE;
            locked_q   <= 1'b0;
            cc_q       <= '0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            valid_q    <= valid_n;
            id_q       <= id_n;
            len_q      <= len_n;
            err_q      <= err_n;
            code_out_q <= code_out_n;
            locked_q   <= locked_n;
            cc_q       <= cc_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        valid_n    = 1'b0;
        id_n       = id_q;
        len_n      = len_q;
        err_n      = 1'b0;
        code_out_n = code_out_q;
        locked_n   = locked_q;
        cc_n       = cc_q;
        fault      = ERR_NONE;
        cur_ph     = state_phase(state_q);
        lim        = phase_limits(cur_ph, 64'(RED_CYCLES), 64'(GREEN_CYCLES),
                                  64'(BLUE_CYCLES), 64'(TOL_CYCLES),
                                  64'(GAP_MAX_CYCLES));

        if (state_q == ST_IDLE) begin
            // Only a gap->red edge starts tracking; everything else is ignored.
            if (code_prev == PH_GAP && code_q == PH_RED) begin
                state_n = ST_RED;
                cnt_n   = CNT_W'(1);
            end
        end else begin
            // Branch order encodes the error priority illegal > order > short.
            // A timeout is only possible while the code is unchanged.
            if (code_q == PH_ILLEGAL) begin
                fault = ERR_ILLEGAL;
            end else if (code_changed) begin
                if (code_q != next_phase(cur_ph)) begin
                    fault = ERR_ORDER;
                end else if (64'(cnt_q) < lim.min_len) begin
                    fault = ERR_SHORT;
                end else begin
                    valid_n = 1'b1;
                    id_n    = cur_ph[1:0];
                    len_n   = cnt_q;
                    state_n = phase_state(code_q);
                    cnt_n   = CNT_W'(1);
                    if (state_q == ST_RED) begin
                        locked_n = 1'b1;
                    end
                    if (state_q == ST_GAP) begin
                        cc_n = (cc_q == 16'hFFFF) ? cc_q : cc_q + 16'd1;
                    end
                end
            end else if (64'(cnt_inc) == lim.limit) begin
                // Fires in the cycle the counter would first equal the limit.
                fault = ERR_TIMEOUT;
            end else begin
                cnt_n = cnt_inc;
            end

            if (fault != ERR_NONE) begin
                err_n      = 1'b1;
                code_out_n = fault;
                locked_n   = 1'b0;
                state_n    = ST_IDLE;
                cnt_n      = '0;
            end
        end
    end

    assign bus.phase_valid = valid_q;
    assign bus.phase_id    = id_q;
    assign bus.phase_len   = len_q;
    assign bus.seq_err     = err_q;
    assign bus.err_code    = code_out_q;
    assign bus.locked      = locked_q;
    assign bus.cycle_count = cc_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_led_sequence_monitor.sv
// -----------------------------------------------------------------------------
// tb_led_sequence_monitor
// Directed bench: RED=20, GREEN=11, BLUE=6, TOL=1, GAP_MAX=4. Lines change on
// the falling edge; each tick() is one rising-edge sample followed by a
// falling-edge look at the outputs. Expected phase_valid results are queued
// as {phase_id, phase_len}.
// -----------------------------------------------------------------------------
module tb_led_sequence_monitor;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    led_mon_if #(.CNT_W(CNT_W)) bus ();

    led_sequence_monitor #(
        .RED_CYCLES     (20),
        .GREEN_CYCLES   (11),
        .BLUE_CYCLES    (6),
        .TOL_CYCLES     (1),
        .GAP_MAX_CYCLES (4),
        .CNT_W          (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int tick_no = 0;
    int err_cnt = 0;
    int err_tick = 0;
    int mark = 0;
    int errs0 = 0;
    logic [2:0] last_err = 3'd0;
    logic [CNT_W+1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard side: one sample per call
    task automatic tick();
        logic [CNT_W+1:0] head;
        @(posedge clk);
        @(negedge clk);
        tick_no++;
        if (rst_n) begin
            if (bus.phase_valid) begin
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", 64'(bus.phase_valid), 64'd0);
                end else begin
                    head = exp_q.pop_front();
                    check("phase_id_len", 64'({bus.phase_id, bus.phase_len}), 64'(head));
                end
            end
            if (bus.seq_err) begin
                err_cnt++;
                last_err = bus.err_code;
                err_tick = tick_no;
            end
        end
    endtask

    // driver tasks
    task automatic hold(input logic [2:0] code, input int n);
        {bus.led_red, bus.led_green, bus.led_blue} = code;
        repeat (n) tick();
    endtask

    task automatic exp_phase(input logic [1:0] id, input int len);
        exp_q.push_back({id, CNT_W'(len)});
    endtask

    task automatic clean_cycle();
        exp_phase(2'd1, 20); hold(3'b100, 20);
        exp_phase(2'd2, 11); hold(3'b010, 11);
        exp_phase(2'd3, 6);  hold(3'b001, 6);
        exp_phase(2'd0, 1);  hold(3'b000, 1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_valid"},  64'(bus.phase_valid), 64'd0);
        check({pfx, "_id"},     64'(bus.phase_id),    64'd0);
        check({pfx, "_len"},    64'(bus.phase_len),   64'd0);
        check({pfx, "_seq_err"},64'(bus.seq_err),     64'd0);
        check({pfx, "_code"},   64'(bus.err_code),    64'd0);
        check({pfx, "_locked"}, 64'(bus.locked),      64'd0);
        check({pfx, "_cycles"}, 64'(bus.cycle_count), 64'd0);
        check({pfx, "_state"},  64'(bus.dbg_state),   64'd0);
    endtask

    initial begin
        {bus.led_red, bus.led_green, bus.led_blue} = 3'b000;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst_n = 1'b1;

        // 1: three clean cycles, lock timing around the first red
        hold(3'b000, 3);
        exp_phase(2'd1, 20); hold(3'b100, 20);
        hold(3'b010, 3);
        check("lock_before_red_done", 64'(bus.locked), 64'd0);
        hold(3'b010, 1);
        check("lock_at_red_valid", 64'(bus.locked), 64'd1);
        exp_phase(2'd2, 11); hold(3'b010, 7);
        exp_phase(2'd3, 6);  hold(3'b001, 6);
        exp_phase(2'd0, 1);  hold(3'b000, 1);
        clean_cycle();
        clean_cycle();
        hold(3'b100, 5);
        check("s1_cycles", 64'(bus.cycle_count), 64'd3);
        check("s1_locked", 64'(bus.locked), 64'd1);
        check("s1_errs", 64'(err_cnt), 64'd0);
        check("s1_pending", 64'(exp_q.size()), 64'd0);

        // 2: red held too long -> timeout when the count reaches 22
        mark = tick_no - 5;
        hold(3'b100, 25);
        check("s2_errs", 64'(err_cnt), 64'd1);
        check("s2_code", 64'(last_err), 64'd4);
        check("s2_err_tick", 64'(err_tick - mark), 64'd25);
        check("s2_locked", 64'(bus.locked), 64'd0);
        check("s2_cycles", 64'(bus.cycle_count), 64'd3);
        check("s2_code_hold", 64'(bus.err_code), 64'd4);
        check("s2_state_idle", 64'(bus.dbg_state), 64'd0);

        // 3: short green, then relock on the next gap->red
        hold(3'b000, 2);
        exp_phase(2'd1, 20); hold(3'b100, 20);
        hold(3'b010, 9);
        hold(3'b001, 6);
        hold(3'b000, 1);
        exp_phase(2'd1, 20); hold(3'b100, 20);
        hold(3'b010, 5);
        check("s3_errs", 64'(err_cnt), 64'd2);
        check("s3_code", 64'(last_err), 64'd3);
        check("s3_relocked", 64'(bus.locked), 64'd1);
        check("s3_cycles", 64'(bus.cycle_count), 64'd3);

        // 4: finish the cycle, then red -> blue directly
        exp_phase(2'd2, 11); hold(3'b010, 6);
        exp_phase(2'd3, 6);  hold(3'b001, 6);
        exp_phase(2'd0, 1);  hold(3'b000, 1);
        hold(3'b100, 20);
        hold(3'b001, 6);
        check("s4_errs", 64'(err_cnt), 64'd3);
        check("s4_code", 64'(last_err), 64'd2);
        check("s4_locked", 64'(bus.locked), 64'd0);
        check("s4_cycles", 64'(bus.cycle_count), 64'd4);

        // 5: red+green both high for one cycle mid-red
        hold(3'b000, 2);
        hold(3'b100, 8);
        hold(3'b110, 1);
        mark = tick_no;
        hold(3'b100, 5);
        check("s5_errs", 64'(err_cnt), 64'd4);
        check("s5_code", 64'(last_err), 64'd1);
        check("s5_err_tick", 64'(err_tick - mark), 64'd3);
        check("s5_pending", 64'(exp_q.size()), 64'd0);

        // 6: reset, two cycles, reset again mid-green
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_idle");
        @(negedge clk);
        rst_n = 1'b1;
        hold(3'b000, 2);
        clean_cycle();
        clean_cycle();
        exp_phase(2'd1, 20); hold(3'b100, 20);
        hold(3'b010, 5);
        check("s6_cycles", 64'(bus.cycle_count), 64'd2);
        check("s6_locked", 64'(bus.locked), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_green");
        @(negedge clk);
        rst_n = 1'b1;
        errs0 = err_cnt;
        hold(3'b010, 6);
        hold(3'b001, 6);
        hold(3'b000, 1);
        exp_phase(2'd1, 20); hold(3'b100, 20);
        hold(3'b010, 4);
        check("s6_no_errs", 64'(err_cnt - errs0), 64'd0);
        check("s6_relocked", 64'(bus.locked), 64'd1);
        check("s6_cycles_after", 64'(bus.cycle_count), 64'd0);
        check("s6_pending", 64'(exp_q.size()), 64'd0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
